// File: rtl/sample_uart_framer.sv
// Captures N_CH signed samples on a decimated strobe and streams them as a framed,
// XOR-checksummed byte sequence through a busy/start UART transmitter handshake.
module sample_uart_framer #(
    parameter int unsigned W     = 16,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DECIM = 1,
    parameter int unsigned OVR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic [N_CH*W-1:0]   samples,
    input  logic                enable,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                frame_active,
    output logic [OVR_W-1:0]    overrun_cnt
);
    localparam int unsigned NB       = (W + 7) / 8;
    localparam int unsigned EXT_W    = NB * 8;
    localparam int unsigned DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned POS_LAST = 2 + NB;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [DEC_W-1:0]  dec_q;
    logic [N_CH*W-1:0] snap_q;
    logic [CH_W-1:0]   ch_q;
    logic [2:0]        pos_q;
    logic              ck_next_q;
    logic              last_q;
    logic [7:0]        csum_q;
    logic [OVR_W-1:0]  ovr_q;
    logic              strobe_hit;
    logic              capture;
    logic              drop;
    logic [EXT_W-1:0]  ext;
    logic [7:0]        cur_byte;

    assign strobe_hit   = sample_clk && enable && (dec_q == DEC_W'(DECIM - 1));
    assign capture      = strobe_hit && (state_q == IDLE);
    assign drop         = strobe_hit && (state_q != IDLE);
    assign frame_active = (state_q != IDLE);
    assign overrun_cnt  = ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= '0;
        end else if (sample_clk && enable) begin
            dec_q <= strobe_hit ? '0 : dec_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= '0;
        end else if (drop && (ovr_q != '1)) begin
            ovr_q <= ovr_q + 1'b1;
        end
    end

    // Byte at (ch_q, pos_q): three header bytes, then the sign-extended sample MSB first.
    always_comb begin
        ext = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (CH_W'(c) == ch_q) begin
                ext = EXT_W'($signed(snap_q[c*W +: W]));
            end
        end
        cur_byte = 8'h00;
        case (pos_q)
            3'd0:    cur_byte = 8'h43;
            3'd1:    cur_byte = 8'h48;
            3'd2:    cur_byte = 8'h30 + 8'(ch_q);
            default: cur_byte = ext[(POS_LAST - 32'(pos_q)) * 8 +: 8];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        case (state_q)
            IDLE:      if (capture) state_d = LOAD;
            LOAD:      state_d = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK:  if (tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = last_q ? IDLE : LOAD;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q    <= '0;
            ch_q      <= '0;
            pos_q     <= '0;
            ck_next_q <= 1'b0;
            last_q    <= 1'b0;
            csum_q    <= 8'h00;
            tx_data   <= 8'h00;
        end else if (capture) begin
            snap_q    <= samples;
            ch_q      <= '0;
            pos_q     <= '0;
            ck_next_q <= 1'b0;
            last_q    <= 1'b0;
            csum_q    <= 8'h00;
        end else if (state_q == LOAD) begin
            if (ck_next_q) begin
                tx_data <= csum_q;
                last_q  <= 1'b1;
            end else begin
                tx_data <= cur_byte;
                csum_q  <= csum_q ^ cur_byte;
                if (pos_q == 3'(POS_LAST)) begin
                    pos_q <= '0;
                    if (ch_q == CH_W'(N_CH - 1)) begin
                        ck_next_q <= 1'b1;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end else begin
                    pos_q <= pos_q + 1'b1;
                end
            end
        end
    end

endmodule
